// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and helpers for the UART blocks.
//   uart_rx_state_t : receiver FSM states
//   tick_divisor()  : clocks per tick for a given clock / tick rate
package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

    // Rounds clk_freq/rate to the nearest whole clock count and never
    // returns less than one, so a tick rate equal to the clock rate
    // degenerates cleanly into "tick every clock".
    function automatic int tick_divisor(input real clk_freq, input real rate);
        int div;
        div = $rtoi(clk_freq / rate + 0.5);
        if (div < 1) begin
            div = 1;
        end
        return div;
    endfunction

endpackage

// File: rtl/uart_baudrate_gen.sv
// uart_baudrate_gen
// Free-running divider producing a one-clock tick at BAUDRATE ticks/s.
//   clk     in  system clock, rising edge
//   reset_n in  asynchronous, active-low reset
//   tick    out one-clock pulse every tick_divisor(CLK_FREQ, BAUDRATE) clocks
module uart_baudrate_gen
    import uart_pkg::*;
#(
    parameter real CLK_FREQ = 100.0e6,
    parameter real BAUDRATE = 115_200.0
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int            DIV  = tick_divisor(CLK_FREQ, BAUDRATE);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The tick is the terminal count itself; with DIV=1 the counter sits at
    // zero and the tick is permanently high.
    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    // Divider count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// 8N1 (by default) UART receiver, LSB first, 16x oversampled.
//   clk          in  system clock, rising edge
//   reset        in  asynchronous, active-high reset
//   rx           in  serial line, asynchronous to clk, idles high
//   rx_data      out received byte, valid while rx_valid=1
//   rx_valid     out holding register full
//   rx_ready     in  consumer accepts; transfer on rx_valid & rx_ready
//   rx_frame_err out 1-clk pulse: stop bit sampled 0, byte dropped
//   rx_overrun   out 1-clk pulse: byte completed while holding register full
module uart_rx
    import uart_pkg::*;
#(
    parameter real CLK_FREQ   = 100.0e6,
    parameter real BAUDRATE   = 115_200.0,
    parameter int  OVERSAMPLE = 16,
    parameter int  DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int            TW     = $clog2(OVERSAMPLE);
    localparam int            NW     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

    uart_rx_state_t       state_q, state_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic [TW-1:0]        t_q, t_d;
    logic [NW-1:0]        n_q, n_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic s_tick;
    logic rxs;
    logic half_point;
    logic bit_end;
    logic stop_sample;
    logic commit;
    logic frame_bad;

    uart_baudrate_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUDRATE (BAUDRATE * OVERSAMPLE)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (~reset),
        .tick    (s_tick)
    );

    // Decode of the shared tick counter and the stop-bit decision point.
    always_comb begin
        sync1_d     = rx;
        sync2_d     = sync1_q;
        rxs         = sync2_q;
        half_point  = (t_q == T_HALF);
        bit_end     = (t_q == T_LAST);
        stop_sample = s_tick && (state_q == STOP) && bit_end;
        commit      = stop_sample && rxs;
        frame_bad   = stop_sample && !rxs;
    end

    // All state, including the two-flop synchroniser which resets to the
    // idle level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= WAIT_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            t_q         <= '0;
            n_q         <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            t_q         <= t_d;
            n_q         <= n_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic. WAIT_IDLE insists on a full bit time of high line
    // before arming: straight after reset the synchroniser still holds its
    // reset value of 1, and trusting that would let a reset in mid-frame
    // decode the tail of the frame as a new byte.
    always_comb begin
        state_d = state_q;
        if (s_tick) begin
            case (state_q)
                WAIT_IDLE: if (rxs && bit_end)  state_d = IDLE;
                IDLE:      if (!rxs)            state_d = START;
                START:     if (half_point)      state_d = rxs ? IDLE : DATA;
                DATA:      if (bit_end && (n_q == N_LAST)) state_d = STOP;
                STOP:      if (bit_end)         state_d = rxs ? IDLE : WAIT_IDLE;
                default:                        state_d = WAIT_IDLE;
            endcase
        end
    end

    // Tick counter, bit counter and shift register. In WAIT_IDLE the tick
    // counter measures how long the line has been continuously high.
    always_comb begin
        t_d     = t_q;
        n_d     = n_q;
        shift_d = shift_q;
        if (s_tick) begin
            case (state_q)
                WAIT_IDLE: begin
                    t_d = (!rxs || bit_end) ? '0 : t_q + TW'(1);
                    n_d = '0;
                end
                IDLE: begin
                    t_d = '0;
                    n_d = '0;
                end
                START: begin
                    t_d = half_point ? '0 : t_q + TW'(1);
                    n_d = '0;
                end
                DATA: begin
                    if (bit_end) begin
                        shift_d[n_q] = rxs;
                        t_d          = '0;
                        n_d          = (n_q == N_LAST) ? '0 : n_q + NW'(1);
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
                STOP: begin
                    t_d = bit_end ? '0 : t_q + TW'(1);
                end
                default: begin
                    t_d = '0;
                    n_d = '0;
                end
            endcase
        end
    end

    // Holding register and flag pulses. A consumer taking the old byte in
    // the same clock as a commit makes room for the new one, so that case
    // loads rather than overruns.
    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = frame_bad;
        overrun_d   = 1'b0;
        if (commit) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = frame_err_q;
    assign rx_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
// Directed bench for uart_rx at 16 MHz / 1 Mbaud (one tick per clock,
// 16 clocks per bit). A table of single frames is followed by hand-written
// sequences for latency, back-to-back frames, glitches, breaks, overrun
// and reset in mid-frame.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT_CLKS = 16;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overrun;

    int checks;
    int errors;
    int cyc;
    int ferr_cnt;
    int ovr_cnt;
    logic [7:0] xfer_q[$];
    int         xfer_cyc[$];
    int base_x;
    int base_f;
    int base_o;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_xfers;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    uart_rx #(
        .CLK_FREQ   (16.0e6),
        .BAUDRATE   (1.0e6),
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle count for latency measurement.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge: record every transfer and flag pulse.
    initial begin
        ferr_cnt = 0;
        ovr_cnt  = 0;
    end
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid && rx_ready) begin
                xfer_q.push_back(rx_data);
                xfer_cyc.push_back(cyc);
            end
            if (rx_frame_err) ferr_cnt <= ferr_cnt + 1;
            if (rx_overrun)   ovr_cnt  <= ovr_cnt + 1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] d, input logic stop, input int idle_bits);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        for (int i = 0; i < idle_bits; i++) drive_bit(1'b1);
    endtask

    task automatic snap();
        base_x = xfer_q.size();
        base_f = ferr_cnt;
        base_o = ovr_cnt;
    endtask

    task automatic check_counts(input string tag, input int xf, input int fe, input int ov);
        check_output({tag, " transfers"}, xfer_q.size() - base_x, xf);
        check_output({tag, " frame_err"}, ferr_cnt - base_f, fe);
        check_output({tag, " overrun"},   ovr_cnt - base_o, ov);
    endtask

    task automatic check_last(input string tag, input logic [7:0] expected);
        if (xfer_q.size() > 0) check_output(tag, xfer_q[xfer_q.size()-1], expected);
        else                   check_output(tag, 32'hxxxx_xxxx, expected);
    endtask

    initial begin
        int c0;
        int lat;
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b1;

        vecs[0] = '{8'h55, 1'b1, 1, 8'h55, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        vecs[3] = '{8'h81, 1'b1, 1, 8'h81, 0};
        vecs[4] = '{8'h6B, 1'b0, 0, 8'h00, 1};
        vecs[5] = '{8'hC4, 1'b1, 1, 8'hC4, 0};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_output("reset rx_data",      rx_data, 0);
        check_output("reset rx_valid",     rx_valid, 0);
        check_output("reset rx_frame_err", rx_frame_err, 0);
        check_output("reset rx_overrun",   rx_overrun, 0);
        reset = 1'b0;
        drive_bit(1'b1);
        drive_bit(1'b1);
        check_output("armed after reset", 32'(dut.state_q), 32'(IDLE));

        // Table of single frames
        for (int v = 0; v < 6; v++) begin
            snap();
            apply_stimulus(vecs[v].data, vecs[v].stop, 3);
            check_counts($sformatf("vec%0d", v), vecs[v].exp_xfers, vecs[v].exp_ferr, 0);
            if (vecs[v].exp_xfers > 0) check_last($sformatf("vec%0d data", v), vecs[v].exp_data);
        end

        // Latency from start edge to rx_valid
        snap();
        c0 = cyc;
        apply_stimulus(8'h55, 1'b1, 2);
        check_counts("latency", 1, 0, 0);
        check_last("latency data", 8'h55);
        lat = (xfer_cyc.size() > 0) ? xfer_cyc[xfer_cyc.size()-1] - c0 : -1;
        check_output("latency in 154..156", 32'((lat >= 154) && (lat <= 156)), 1);

        // Back-to-back frames with a single stop bit
        snap();
        apply_stimulus(8'hA3, 1'b1, 0);
        apply_stimulus(8'h3C, 1'b1, 2);
        check_counts("b2b", 2, 0, 0);
        if (xfer_q.size() >= base_x + 2) begin
            check_output("b2b first",  xfer_q[base_x],     8'hA3);
            check_output("b2b second", xfer_q[base_x + 1], 8'h3C);
        end else begin
            check_output("b2b present", xfer_q.size() - base_x, 2);
        end

        // Short glitch rejected
        snap();
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        drive_bit(1'b1);
        drive_bit(1'b1);
        check_counts("glitch", 0, 0, 0);
        check_output("glitch state", 32'(dut.state_q), 32'(IDLE));
        snap();
        apply_stimulus(8'h81, 1'b1, 2);
        check_counts("post glitch", 1, 0, 0);
        check_last("post glitch data", 8'h81);

        // Frame error followed by a long break
        snap();
        apply_stimulus(8'hFF, 1'b0, 0);
        for (int i = 0; i < 40; i++) drive_bit(1'b0);
        for (int i = 0; i < 3; i++)  drive_bit(1'b1);
        check_counts("break", 0, 1, 0);
        snap();
        apply_stimulus(8'h12, 1'b1, 2);
        check_counts("post break", 1, 0, 0);
        check_last("post break data", 8'h12);

        // Overrun while the consumer stalls
        snap();
        rx_ready = 1'b0;
        apply_stimulus(8'h11, 1'b1, 2);
        apply_stimulus(8'h22, 1'b1, 2);
        check_counts("overrun", 0, 0, 1);
        check_output("overrun rx_valid", rx_valid, 1);
        check_output("overrun rx_data",  rx_data, 8'h11);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        check_counts("accept", 1, 0, 1);
        check_last("accept data", 8'h11);
        check_output("accept rx_valid", rx_valid, 0);

        // Reset in mid-frame with the line low
        apply_stimulus(8'h5A, 1'b1, 2);
        check_output("held before reset", rx_data, 8'h5A);
        snap();
        for (int i = 0; i < 5; i++) drive_bit(1'b0);
        rx = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_output("async reset rx_data",      rx_data, 0);
        check_output("async reset rx_valid",     rx_valid, 0);
        check_output("async reset rx_frame_err", rx_frame_err, 0);
        check_output("async reset rx_overrun",   rx_overrun, 0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rx_ready = 1'b1;
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        check_counts("after reset", 0, 0, 0);
        snap();
        apply_stimulus(8'h7E, 1'b1, 3);
        check_counts("post reset frame", 1, 0, 0);
        check_last("post reset data", 8'h7E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
